// File: rtl/bc_pkg.sv
// Shared types and constants for the station barcode receiver.
// Imported by barcode_rcv; the synchroniser needs nothing from here.
package bc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_FALL,
    SAMPLE
  } bc_state_t;

  localparam int         ID_BITS   = 8;
  localparam logic [1:0] VALID_TOP = 2'b00;

endpackage

// File: rtl/bc_sync.sv
// Two-flop synchroniser for the asynchronous BC pin plus one delay flop for
// edge detection. Everything presets high so reset never fakes a falling edge.
module bc_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic BC,
  output logic BC_s,
  output logic fall,
  output logic rise
);

  logic bc_meta;
  logic BC_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bc_meta <= 1'b1;
      BC_s    <= 1'b1;
      BC_d    <= 1'b1;
    end else begin
      bc_meta <= BC;
      BC_s    <= bc_meta;
      BC_d    <= BC_s;
    end
  end

  assign fall = BC_d & ~BC_s;
  assign rise = ~BC_d & BC_s;

endmodule

// File: rtl/barcode_rcv.sv
// Barcode receiver: measures the bit period from the start bit, samples eight
// data bits MSB first and presents a validated station ID with a sticky flag.
module barcode_rcv
  import bc_pkg::*;
#(
  parameter int CNT_W    = 22,
  parameter int MIN_T    = 4,
  parameter int TO_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               BC,
  input  logic               clr_ID_vld,
  output logic [ID_BITS-1:0] ID,
  output logic               ID_vld,
  output logic               frm_err
);

  // The between-bit timeout is T << TO_SHIFT, so the shared counter is widened
  // to hold it without truncation; START still aborts at the CNT_W all-ones.
  localparam int TO_W = CNT_W + TO_SHIFT;
  localparam logic [TO_W-1:0] CNT_MAX = {{TO_SHIFT{1'b0}}, {CNT_W{1'b1}}};
  localparam logic [TO_W-1:0] MIN_CNT = TO_W'(MIN_T);
  localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

  logic BC_s, fall, rise;

  bc_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .BC   (BC),
    .BC_s (BC_s),
    .fall (fall),
    .rise (rise)
  );

  bc_state_t          state, state_nxt;
  logic [TO_W-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0]   t_per, t_nxt;
  logic [3:0]         bit_cnt, bit_cnt_nxt;
  logic [ID_BITS-1:0] shft, shft_nxt;
  logic               eval_pend, eval_nxt;
  logic               err_nxt;
  logic [TO_W-1:0]    t_ext;
  logic [TO_W-1:0]    t_limit;
  logic               frame_ok;

  assign t_ext    = {{TO_SHIFT{1'b0}}, t_per};
  assign t_limit  = t_ext << TO_SHIFT;
  assign frame_ok = (shft[ID_BITS-1 -: 2] == VALID_TOP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      t_per     <= '0;
      bit_cnt   <= '0;
      shft      <= '0;
      eval_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      t_per     <= t_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shft      <= shft_nxt;
      eval_pend <= eval_nxt;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    t_nxt       = t_per;
    bit_cnt_nxt = bit_cnt;
    shft_nxt    = shft;
    eval_nxt    = 1'b0;
    err_nxt     = 1'b0;

    unique case (state)
      IDLE: begin
        if (fall) begin
          cnt_nxt     = CNT_ONE;
          bit_cnt_nxt = '0;
          state_nxt   = START;
        end
      end

      START: begin
        if (rise) begin
          if (cnt < MIN_CNT) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            t_nxt     = cnt[CNT_W-1:0];
            cnt_nxt   = '0;
            state_nxt = WAIT_FALL;
          end
        end else if (cnt == CNT_MAX) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (!BC_s) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      WAIT_FALL: begin
        if (fall) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = SAMPLE;
        end else if (cnt == t_limit) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      SAMPLE: begin
        // One period T after the falling edge a '1' is already high again
        // (low T/2) while a '0' is still low (low 3T/2).
        if (cnt == t_ext) begin
          shft_nxt    = {shft[ID_BITS-2:0], BC_s};
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            eval_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = '0;
            state_nxt = WAIT_FALL;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Evaluation runs while the FSM is already back in IDLE, so a new start
  // bit can be accepted in the same clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ID      <= '0;
      ID_vld  <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      frm_err <= err_nxt | (eval_pend & ~frame_ok);
      if (eval_pend && frame_ok) begin
        ID     <= shft;
        ID_vld <= 1'b1;
      end else if (clr_ID_vld) begin
        ID_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_barcode_rcv.sv
// Directed and randomized bench for barcode_rcv: a behavioural transmitter
// drives BC and a small model tracks the expected ID, valid flag and errors.
module tb_barcode_rcv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bc;
  logic       clr;
  logic       sel_n;
  logic       bc_w, bc_n;
  logic [7:0] id_w, id_n;
  logic       vld_w, vld_n, err_w, err_n;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt_w = 0;
  int err_cnt_n = 0;

  logic [7:0] exp_id;
  logic       exp_vld;
  int         exp_err;

  always #5 clk = ~clk;

  // The idle DUT sees a permanently high line.
  assign bc_w = sel_n ? 1'b1 : bc;
  assign bc_n = sel_n ? bc : 1'b1;

  barcode_rcv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .BC        (bc_w),
    .clr_ID_vld(clr),
    .ID        (id_w),
    .ID_vld    (vld_w),
    .frm_err   (err_w)
  );

  barcode_rcv #(.CNT_W(8), .MIN_T(4), .TO_SHIFT(2)) dut_n (
    .clk       (clk),
    .rst_n     (rst_n),
    .BC        (bc_n),
    .clr_ID_vld(clr),
    .ID        (id_n),
    .ID_vld    (vld_n),
    .frm_err   (err_n)
  );

  // Counts high cycles, so a pulse wider than one clock shows up as extra errors.
  always @(posedge clk) begin
    if (err_w === 1'b1) err_cnt_w++;
    if (err_n === 1'b1) err_cnt_n++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: start bit low P/2, '1' low P/4, '0' low 3P/4, each bit
  // P clocks long. nbits < 8 truncates the frame; short_last trims the last
  // bit to T+1 clocks. chk_lat checks ID_vld around the set clock, which lies
  // T+4 clocks after the final falling edge is driven.
  task automatic send(input int p, input logic [7:0] id, input int nbits,
                      input bit short_last, input bit chk_lat, input bit clr_at_set);
    int t;
    int low;
    int len;
    t = p / 2;
    for (int bi = 0; bi <= nbits; bi++) begin
      if (bi == 0) low = t;
      else low = id[8-bi] ? p / 4 : 3 * p / 4;
      len = (bi == 8 && short_last) ? t + 1 : p;
      for (int k = 0; k < len; k++) begin
        bc  = (k < low) ? 1'b0 : 1'b1;
        clr = (bi == 8 && clr_at_set && k == t + 3) ? 1'b1 : 1'b0;
        step(1);
        if (bi == 8 && chk_lat && k == t + 2) check("vld_before_set", 32'(vld_w), 32'd0);
        if (bi == 8 && chk_lat && k == t + 3) begin
          check("vld_at_set", 32'(vld_w), 32'd1);
          check("id_at_set", 32'(id_w), 32'(id));
        end
      end
    end
    bc  = 1'b1;
    clr = 1'b0;
  endtask

  initial begin
    int         p;
    logic [7:0] rid;

    rst_n = 1'b0;
    bc    = 1'b1;
    clr   = 1'b0;
    sel_n = 1'b0;
    step(3);
    check("rst_id", 32'(id_w), 32'd0);
    check("rst_vld", 32'(vld_w), 32'd0);
    check("rst_err", 32'(err_w), 32'd0);
    check("rst_vld_n", 32'(vld_n), 32'd0);
    rst_n = 1'b1;
    step(5);

    send(32'h1000, 8'h05, 8, 1'b0, 1'b1, 1'b0);
    step(4);
    check("p1000_id", 32'(id_w), 32'h05);
    check("p1000_vld", 32'(vld_w), 32'd1);
    check("p1000_err", err_cnt_w, 32'd0);

    send(64, 8'h01, 8, 1'b0, 1'b0, 1'b0);
    step(4);
    check("id01", 32'(id_w), 32'h01);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("vld_clr", 32'(vld_w), 32'd0);
    send(64, 8'h02, 8, 1'b0, 1'b1, 1'b1);
    step(4);
    check("id02", 32'(id_w), 32'h02);
    check("vld02_set_wins", 32'(vld_w), 32'd1);
    check("err02", err_cnt_w, 32'd0);

    send(64, 8'hC1, 8, 1'b0, 1'b0, 1'b0);
    step(4);
    check("c1_err", err_cnt_w, 32'd1);
    check("c1_id_kept", 32'(id_w), 32'h02);
    check("c1_vld_kept", 32'(vld_w), 32'd1);

    bc = 1'b0;
    step(3);
    bc = 1'b1;
    step(10);
    check("glitch_err", err_cnt_w, 32'd2);
    send(64, 8'h15, 8, 1'b0, 1'b0, 1'b0);
    step(4);
    check("after_glitch_id", 32'(id_w), 32'h15);
    check("after_glitch_err", err_cnt_w, 32'd2);

    // Timeout: T=32, pulse lands 5T+4 edges after the third bit's fall is driven.
    send(64, 8'h15, 3, 1'b0, 1'b0, 1'b0);
    step(3 * 32 + 3);
    check("to_early", 32'(err_w), 32'd0);
    step(1);
    check("to_pulse", 32'(err_w), 32'd1);
    step(1);
    check("to_width", 32'(err_w), 32'd0);
    check("to_err", err_cnt_w, 32'd3);
    check("to_id_kept", 32'(id_w), 32'h15);

    send(64, 8'h15, 3, 1'b0, 1'b0, 1'b0);
    bc = 1'b0;
    step(10);
    rst_n = 1'b0;
    bc    = 1'b1;
    step(1);
    rst_n = 1'b1;
    check("midrst_id", 32'(id_w), 32'd0);
    check("midrst_vld", 32'(vld_w), 32'd0);
    step(300);
    check("midrst_err", err_cnt_w, 32'd3);
    check("midrst_vld_idle", 32'(vld_w), 32'd0);
    send(64, 8'h3F, 8, 1'b0, 1'b0, 1'b0);
    step(4);
    check("id3f", 32'(id_w), 32'h3F);
    check("vld3f", 32'(vld_w), 32'd1);

    send(64, 8'h11, 8, 1'b1, 1'b0, 1'b0);
    send(64, 8'h22, 8, 1'b0, 1'b0, 1'b0);
    step(4);
    check("b2b_id", 32'(id_w), 32'h22);
    check("b2b_err", err_cnt_w, 32'd3);

    send(16, 8'h2A, 8, 1'b0, 1'b0, 1'b0);
    step(4);
    check("pmin_id", 32'(id_w), 32'h2A);

    // Narrow counter instance: period near the top of an 8-bit counter.
    sel_n = 1'b1;
    step(5);
    send(32'h1F0, 8'h2A, 8, 1'b0, 1'b0, 1'b0);
    step(4);
    check("pmax_id", 32'(id_n), 32'h2A);
    check("pmax_vld", 32'(vld_n), 32'd1);
    check("pmax_err", err_cnt_n, 32'd0);
    bc = 1'b0;
    step(300);
    bc = 1'b1;
    step(20);
    check("start_ovf_err", err_cnt_n, 32'd1);
    check("start_ovf_id", 32'(id_n), 32'h2A);
    send(32'h1F0, 8'h00, 1, 1'b0, 1'b0, 1'b0);
    step(1100);
    check("wide_to_err", err_cnt_n, 32'd2);
    sel_n = 1'b0;
    step(5);

    exp_id  = 8'h2A;
    exp_vld = 1'b1;
    exp_err = 3;
    for (int i = 0; i < 12; i++) begin
      p   = 4 * int'($urandom_range(4, 40));
      rid = 8'($urandom_range(0, 255));
      if (i % 2 == 0) rid[7:6] = 2'b00;
      if ($urandom_range(0, 1) == 1) begin
        clr = 1'b1;
        step(1);
        clr     = 1'b0;
        exp_vld = 1'b0;
        check("rnd_clr", 32'(vld_w), 32'(exp_vld));
      end
      send(p, rid, 8, 1'b0, 1'b0, 1'b0);
      step(4);
      if (rid[7:6] == 2'b00) begin
        exp_id  = rid;
        exp_vld = 1'b1;
      end else begin
        exp_err++;
      end
      check("rnd_id", 32'(id_w), 32'(exp_id));
      check("rnd_vld", 32'(vld_w), 32'(exp_vld));
      check("rnd_err", err_cnt_w, exp_err);
    end

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
